// File: rtl/video_timing_gen_if.sv
// Raster timing bundle carried from video_timing_gen to the test-pattern generator.
interface video_timing_gen_if;
   logic [11:0] O_active_x;
   logic [11:0] O_active_y;
   logic        O_de;
   logic        O_hs;
   logic        O_vs;
   logic        O_frame_start;
   logic [15:0] O_frame_cnt;

   modport master (
      output O_active_x, O_active_y, O_de, O_hs, O_vs, O_frame_start, O_frame_cnt
   );
   modport slave (
      input  O_active_x, O_active_y, O_de, O_hs, O_vs, O_frame_start, O_frame_cnt
   );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running 1280x720 raster timing generator with registered sync/DE/coordinates.
// Optional frame counter enabled by defining VTG_FRAME_CNT_EN.
module video_timing_gen #(
   parameter int unsigned H_ACTIVE = 1280,
   parameter int unsigned H_FP     = 110,
   parameter int unsigned H_SYNC   = 40,
   parameter int unsigned H_BP     = 220,
   parameter int unsigned V_ACTIVE = 720,
   parameter int unsigned V_FP     = 5,
   parameter int unsigned V_SYNC   = 5,
   parameter int unsigned V_BP     = 20,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1
) (
   input  logic               I_pix_clk,
   input  logic               I_rst_n,
   video_timing_gen_if.master vid
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

   logic [11:0] h_cnt, v_cnt;
   logic        h_wrap, v_wrap;
   logic        h_act, v_act, hs_on, vs_on;

   logic [11:0] active_x_q, active_y_q;
   logic        de_q, hs_q, vs_q, frame_start_q;

   always_comb begin
      h_wrap = (h_cnt == H_LAST);
      v_wrap = (v_cnt == V_LAST);
      h_act  = (h_cnt < H_ACT);
      v_act  = (v_cnt < V_ACT);
      hs_on  = (h_cnt >= HS_START) && (h_cnt < HS_END);
      vs_on  = (v_cnt >= VS_START) && (v_cnt < VS_END);
   end

   always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_wrap ? '0 : h_cnt + 12'd1;
         if (h_wrap)
            v_cnt <= v_wrap ? '0 : v_cnt + 12'd1;
      end
   end

   // All outputs share one register stage so sync and coordinates stay aligned.
   always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         active_x_q    <= '0;
         active_y_q    <= '0;
         de_q          <= 1'b0;
         hs_q          <= ~HS_POL;
         vs_q          <= ~VS_POL;
         frame_start_q <= 1'b0;
      end else begin
         active_x_q    <= h_act ? h_cnt : '0;
         active_y_q    <= v_act ? v_cnt : '0;
         de_q          <= h_act && v_act;
         hs_q          <= hs_on ? HS_POL : ~HS_POL;
         vs_q          <= vs_on ? VS_POL : ~VS_POL;
         frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

`ifdef VTG_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
      if (!I_rst_n)
         frame_cnt_q <= '0;
      else if (frame_start_q)
         frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign vid.O_frame_cnt = frame_cnt_q;
`else
   assign vid.O_frame_cnt = '0;
`endif

   assign vid.O_active_x    = active_x_q;
   assign vid.O_active_y    = active_y_q;
   assign vid.O_de          = de_q;
   assign vid.O_hs          = hs_q;
   assign vid.O_vs          = vs_q;
   assign vid.O_frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 1280x720 instance for line timing and reset, small inverted-polarity instance for frame timing.
module tb_video_timing_gen;

   localparam int BH = 1650;
   localparam int SH = 14;
   localparam int SF = 98;
`ifdef VTG_FRAME_CNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   video_timing_gen_if big ();
   video_timing_gen_if sm ();

   video_timing_gen dut_big (
      .I_pix_clk (clk),
      .I_rst_n   (rst_n),
      .vid       (big)
   );

   video_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .HS_POL   (1'b0), .VS_POL (1'b0)
   ) dut_sm (
      .I_pix_clk (clk),
      .I_rst_n   (rst_n),
      .vid       (sm)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int hb, ls, fo;
   int b_de, b_hs, b_hs_first, b_vs;
   int s_hs, s_hs_first, s_vs, s_vs_first, s_de_act, s_de_blank, s_last_fs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " big x"},  32'(big.O_active_x), 0);
      chk({tag, " big y"},  32'(big.O_active_y), 0);
      chk({tag, " big de"}, 32'(big.O_de), 0);
      chk({tag, " big hs"}, 32'(big.O_hs), 0);
      chk({tag, " big vs"}, 32'(big.O_vs), 0);
      chk({tag, " big fs"}, 32'(big.O_frame_start), 0);
      chk({tag, " big fc"}, 32'(big.O_frame_cnt), 0);
      chk({tag, " sm hs"},  32'(sm.O_hs), 1);
      chk({tag, " sm vs"},  32'(sm.O_vs), 1);
      chk({tag, " sm de"},  32'(sm.O_de), 0);
   endtask

   task automatic chk_first_edges(input string tag);
      step();
      chk({tag, " e1 de"}, 32'(big.O_de), 1);
      chk({tag, " e1 x"},  32'(big.O_active_x), 0);
      chk({tag, " e1 y"},  32'(big.O_active_y), 0);
      chk({tag, " e1 fs"}, 32'(big.O_frame_start), 1);
      chk({tag, " e1 sm fs"}, 32'(sm.O_frame_start), 1);
      step();
      chk({tag, " e2 x"},  32'(big.O_active_x), 1);
      chk({tag, " e2 fs"}, 32'(big.O_frame_start), 0);
      chk({tag, " e2 fc"}, 32'(big.O_frame_cnt), FC_EN ? 1 : 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");

      @(negedge clk);
      rst_n = 1'b1;

      b_vs = 0;
      s_last_fs = -1;
      for (int n = 0; n < 3 * BH; n++) begin
         step();
         hb = n % BH;
         ls = n % SH;
         fo = n % SF;

         if (n == 0) begin
            chk("rel e1 de", 32'(big.O_de), 1);
            chk("rel e1 x",  32'(big.O_active_x), 0);
            chk("rel e1 y",  32'(big.O_active_y), 0);
            chk("rel e1 fs", 32'(big.O_frame_start), 1);
            chk("rel e1 fc", 32'(big.O_frame_cnt), 0);
         end
         if (n == 1) begin
            chk("rel e2 x",  32'(big.O_active_x), 1);
            chk("rel e2 fs", 32'(big.O_frame_start), 0);
            chk("rel e2 fc", 32'(big.O_frame_cnt), FC_EN ? 1 : 0);
         end

         // default instance: per-line DE / HS run measurement
         if (hb == 0) begin
            b_de = 0; b_hs = 0; b_hs_first = -1;
         end
         if (big.O_de) b_de++;
         if (big.O_hs) begin
            if (b_hs_first < 0) b_hs_first = hb;
            b_hs++;
         end
         if (big.O_vs) b_vs++;
         if (hb == 1279) begin
            chk("big last x", 32'(big.O_active_x), 1279);
            chk("big line y", 32'(big.O_active_y), 32'(n / BH));
         end
         if (hb == 1280) chk("big fp x", 32'(big.O_active_x), 0);
         if (hb == BH - 1) begin
            chk("big de len",   32'(b_de), 1280);
            chk("big hs len",   32'(b_hs), 40);
            chk("big hs start", 32'(b_hs_first), 1390);
         end

         // small instance: frame period, VS/HS placement, DE blanking
         if (sm.O_frame_start) begin
            if (s_last_fs >= 0) chk("sm fs period", 32'(n - s_last_fs), SF);
            else chk("sm first fs", 32'(n), 0);
            s_last_fs = n;
         end
         if (ls == 0) begin
            s_hs = 0; s_hs_first = -1;
         end
         if (!sm.O_hs) begin
            if (s_hs_first < 0) s_hs_first = ls;
            s_hs++;
         end
         if (ls == SH - 1 && n < SF) begin
            chk("sm hs len",   32'(s_hs), 2);
            chk("sm hs start", 32'(s_hs_first), 10);
         end
         if (fo == 0) begin
            s_vs = 0; s_vs_first = -1; s_de_act = 0; s_de_blank = 0;
         end
         if (!sm.O_vs) begin
            if (s_vs_first < 0) s_vs_first = fo;
            s_vs++;
         end
         if (sm.O_de) begin
            if (fo < 4 * SH) s_de_act++;
            else s_de_blank++;
         end
         if (fo == SF - 1) begin
            chk("sm vs len",      32'(s_vs), 14);
            chk("sm vs start",    32'(s_vs_first), 70);
            chk("sm de active",   32'(s_de_act), 32);
            chk("sm de blanking", 32'(s_de_blank), 0);
         end
         if (n == 49) begin
            chk("sm wrap last x",  32'(sm.O_active_x), 7);
            chk("sm wrap last y",  32'(sm.O_active_y), 3);
            chk("sm wrap last de", 32'(sm.O_de), 1);
         end
         if (n == 50) chk("sm after last de", 32'(sm.O_de), 0);
         if (n == SF) begin
            chk("sm wrap de", 32'(sm.O_de), 1);
            chk("sm wrap x",  32'(sm.O_active_x), 0);
            chk("sm wrap y",  32'(sm.O_active_y), 0);
            chk("sm wrap fs", 32'(sm.O_frame_start), 1);
         end
         if (n == 2 * SF + 1) chk("sm frame cnt", 32'(sm.O_frame_cnt), FC_EN ? 3 : 0);
      end
      chk("big vs idle", 32'(b_vs), 0);

      // run the default instance to x = 700 on line 3, then reset mid-line
      repeat (701) step();
      chk("pre-rst x", 32'(big.O_active_x), 700);
      chk("pre-rst y", 32'(big.O_active_y), 3);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      repeat (5) step();
      chk_reset_vals("held");

      @(negedge clk);
      rst_n = 1'b1;
      chk_first_edges("rerel");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
